// File: rtl/rx_nrzi_unstuff_if.sv
// -----------------------------------------------------------------------------
// rx_nrzi_unstuff_if
//   Signal bundle between the DP/DM reader, the NRZI/unstuff stage and the
//   PID/field deserializer.
//
//   Parameter
//     LEN_W      width of pkt_len; must match the LEN_W of rx_nrzi_unstuff.
//
//   Signals
//     in_bit     line level (DP), one bit per clk          (master -> slave)
//     in_valid   packet-active qualifier                   (master -> slave)
//     out_bit    decoded, unstuffed data bit               (slave -> master)
//     out_valid  out_bit is a payload bit                  (slave -> master)
//     pkt_start  1-cycle pulse, SYNC matched               (slave -> master)
//     pkt_end    1-cycle pulse, packet closed cleanly      (slave -> master)
//     pkt_len    payload bit count, valid with pkt_end     (slave -> master)
//     stuff_err  1-cycle pulse, seventh consecutive 1 seen (slave -> master)
//     sync_err   1-cycle pulse, strict SYNC mismatch       (slave -> master)
//
//   Modports
//     master     upstream/consumer side (drives the line, observes results)
//     slave      the decoding stage itself
// -----------------------------------------------------------------------------
interface rx_nrzi_unstuff_if #(
    parameter int LEN_W = 7
) ();
    logic             in_bit;
    logic             in_valid;
    logic             out_bit;
    logic             out_valid;
    logic             pkt_start;
    logic             pkt_end;
    logic [LEN_W-1:0] pkt_len;
    logic             stuff_err;
    logic             sync_err;

    modport master (
        output in_bit, in_valid,
        input  out_bit, out_valid, pkt_start, pkt_end, pkt_len, stuff_err, sync_err
    );

    modport slave (
        input  in_bit, in_valid,
        output out_bit, out_valid, pkt_start, pkt_end, pkt_len, stuff_err, sync_err
    );
endinterface

// File: rtl/rx_nrzi_unstuff.sv
// -----------------------------------------------------------------------------
// rx_nrzi_unstuff
//   Receive-side stage behind the DP/DM reader. NRZI-decodes the raw line
//   level, hunts for and strips SYNC, removes stuffed bits, flags stuffing
//   errors and frames the payload with pkt_start / pkt_end pulses.
//   Every output is registered; a line sample appears on out_bit/out_valid
//   one clk after it is sampled.
//
//   Parameters
//     SYNC_PAT   decoded SYNC pattern, first received bit is the MSB
//     LEN_W      width of the saturating payload length counter
//     STUFF_RUN  number of consecutive decoded 1s followed by a stuff bit
//
//   Ports
//     clk        system clock
//     rst        synchronous, active-high reset
//     bus        rx_nrzi_unstuff_if.slave (in_bit, in_valid in; out_bit,
//                out_valid, pkt_start, pkt_end, pkt_len, stuff_err,
//                sync_err out)
//
//   Build option
//     RX_SYNC_STRICT_EN  when defined, the first 8 decoded bits of a packet
//                        must be exactly SYNC_PAT, otherwise sync_err pulses
//                        and the packet is drained. When undefined, SYNC is
//                        searched with a sliding window and sync_err is 0.
// -----------------------------------------------------------------------------
module rx_nrzi_unstuff #(
    parameter logic [7:0] SYNC_PAT  = 8'b0000_0001,
    parameter int         LEN_W     = 7,
    parameter int         STUFF_RUN = 6
) (
    input logic              clk,
    input logic              rst,
    rx_nrzi_unstuff_if.slave bus
);

    localparam int                ONES_W    = $clog2(STUFF_RUN + 1);
    localparam logic [ONES_W-1:0] STUFF_MAX = ONES_W'(STUFF_RUN);

    typedef enum logic [1:0] {
        IDLE,
        HUNT,
        DATA,
        ERR
    } state_t;

    state_t            state_q;
    logic              prev_level_q;
    logic [ONES_W-1:0] ones_cnt_q;
    // Only the 7 newest bits are stored; the 8th comparison bit is the
    // current decoded bit, so the oldest bit of the window is never needed.
    logic [6:0]        sync_q;
    logic              out_bit_q;
    logic              out_valid_q;
    logic              pkt_start_q;
    logic              pkt_end_q;
    logic [LEN_W-1:0]  pkt_len_q;
    logic              stuff_err_q;
`ifdef RX_SYNC_STRICT_EN
    logic              sync_err_q;
    logic [2:0]        hunt_cnt_q;  // decoded bits already taken into sync_q
`endif

    logic       dec_bit;
    logic [7:0] sync_win;

    // No line transition decodes as 1, a transition as 0.
    assign dec_bit  = ~(bus.in_bit ^ prev_level_q);
    assign sync_win = {sync_q, dec_bit};

    function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] v);
        return (&v) ? v : v + LEN_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            prev_level_q <= 1'b1;
            ones_cnt_q   <= '0;
            sync_q       <= '0;
            out_bit_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            pkt_start_q  <= 1'b0;
            pkt_end_q    <= 1'b0;
            pkt_len_q    <= '0;
            stuff_err_q  <= 1'b0;
`ifdef RX_SYNC_STRICT_EN
            sync_err_q   <= 1'b0;
            hunt_cnt_q   <= '0;
`endif
        end else begin
            out_valid_q  <= 1'b0;
            pkt_start_q  <= 1'b0;
            pkt_end_q    <= 1'b0;
            stuff_err_q  <= 1'b0;
`ifdef RX_SYNC_STRICT_EN
            sync_err_q   <= 1'b0;
`endif
            // Outside a packet the line idles at J, so the reference level
            // for the first bit of the next packet is 1.
            prev_level_q <= bus.in_valid ? bus.in_bit : 1'b1;

            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        sync_q     <= sync_win[6:0];
                        state_q    <= HUNT;
`ifdef RX_SYNC_STRICT_EN
                        hunt_cnt_q <= 3'd1;
`endif
                    end else begin
                        sync_q <= '0;
                    end
                end

                HUNT: begin
                    // A falling in_valid wins over a SYNC completing in the
                    // same cycle.
                    if (!bus.in_valid) begin
                        sync_q  <= '0;
                        state_q <= IDLE;
                    end else begin
                        sync_q <= sync_win[6:0];
`ifdef RX_SYNC_STRICT_EN
                        if (hunt_cnt_q == 3'd7) begin
                            if (sync_win == SYNC_PAT) begin
                                pkt_start_q <= 1'b1;
                                ones_cnt_q  <= ONES_W'(1);
                                pkt_len_q   <= '0;
                                state_q     <= DATA;
                            end else begin
                                sync_err_q  <= 1'b1;
                                state_q     <= ERR;
                            end
                        end else begin
                            hunt_cnt_q <= hunt_cnt_q + 3'd1;
                        end
`else
                        if (sync_win == SYNC_PAT) begin
                            pkt_start_q <= 1'b1;
                            // SYNC ends in a decoded 1, which opens the run.
                            ones_cnt_q  <= ONES_W'(1);
                            pkt_len_q   <= '0;
                            state_q     <= DATA;
                        end
`endif
                    end
                end

                DATA: begin
                    if (!bus.in_valid) begin
                        // A stuff position pending at EOP is not an error.
                        pkt_end_q  <= 1'b1;
                        ones_cnt_q <= '0;
                        sync_q     <= '0;
                        state_q    <= IDLE;
                    end else if (ones_cnt_q == STUFF_MAX) begin
                        if (dec_bit) begin
                            stuff_err_q <= 1'b1;
                            state_q     <= ERR;
                        end else begin
                            ones_cnt_q  <= '0;
                        end
                    end else begin
                        out_bit_q   <= dec_bit;
                        out_valid_q <= 1'b1;
                        pkt_len_q   <= sat_inc(pkt_len_q);
                        ones_cnt_q  <= dec_bit ? ones_cnt_q + ONES_W'(1) : '0;
                    end
                end

                ERR: begin
                    // Drain the rest of the packet silently.
                    if (!bus.in_valid) begin
                        ones_cnt_q <= '0;
                        sync_q     <= '0;
                        state_q    <= IDLE;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.out_bit   = out_bit_q;
    assign bus.out_valid = out_valid_q;
    assign bus.pkt_start = pkt_start_q;
    assign bus.pkt_end   = pkt_end_q;
    assign bus.pkt_len   = pkt_len_q;
    assign bus.stuff_err = stuff_err_q;
`ifdef RX_SYNC_STRICT_EN
    assign bus.sync_err  = sync_err_q;
`else
    assign bus.sync_err  = 1'b0;
`endif

endmodule

// File: tb/tb_rx_nrzi_unstuff.sv
`timescale 1ns/1ps
module tb_rx_nrzi_unstuff;
    localparam int LEN_W = 7;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rx_nrzi_unstuff_if #(.LEN_W(LEN_W)) bus ();

    rx_nrzi_unstuff #(
        .SYNC_PAT (8'b0000_0001),
        .LEN_W    (LEN_W),
        .STUFF_RUN(6)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_vec = 0;
    int n_mis = 0;

    // Observations gathered while stepping.
    int cyc, n_start, n_end, n_stuff, n_sync, n_vld;
    int start_cyc, end_cyc, err_cyc, first_vld, last_vld;
    logic [LEN_W-1:0] end_len;
    logic got_q[$];
    logic exp_q[$];

    // Transmit-side NRZI encoder state.
    logic tx_level;
    int   tx_ones;

    task automatic clear_obs();
        cyc = 0; n_start = 0; n_end = 0; n_stuff = 0; n_sync = 0; n_vld = 0;
        start_cyc = 0; end_cyc = 0; err_cyc = 0; first_vld = 0; last_vld = 0;
        end_len = '0;
        got_q.delete();
        exp_q.delete();
    endtask

    // Drive one line sample, clock it in and record what the DUT produced.
    task automatic step(input logic lvl, input logic vld);
        bus.in_bit   = lvl;
        bus.in_valid = vld;
        @(posedge clk);
        #1;
        cyc++;
        if (bus.out_valid) begin
            got_q.push_back(bus.out_bit);
            n_vld++;
            if (first_vld == 0) first_vld = cyc;
            last_vld = cyc;
        end
        if (bus.pkt_start) begin n_start++; start_cyc = cyc; end
        if (bus.pkt_end)   begin n_end++; end_cyc = cyc; end_len = bus.pkt_len; end
        if (bus.stuff_err) begin n_stuff++; err_cyc = cyc; end
        if (bus.sync_err)  begin n_sync++; err_cyc = cyc; end
    endtask

    // KJKJKJKK starting from idle J.
    task automatic send_sync();
        logic [7:0] lv;
        lv = 8'b0101_0100;
        for (int i = 7; i >= 0; i--) step(lv[i], 1'b1);
        tx_level = 1'b0;
        tx_ones  = 1;
    endtask

    // Transmitter: insert a stuff 0 after six 1s, encode 0 as a transition.
    task automatic send_bit(input logic b);
        if (tx_ones == 6) begin
            tx_level = ~tx_level;
            step(tx_level, 1'b1);
            tx_ones = 0;
        end
        if (!b) tx_level = ~tx_level;
        step(tx_level, 1'b1);
        exp_q.push_back(b);
        tx_ones = b ? tx_ones + 1 : 0;
    endtask

    task automatic test_reset();
        logic [12:0] obs;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_bit   = i[0];
            @(posedge clk);
            #1;
            obs = {bus.out_bit, bus.out_valid, bus.pkt_start, bus.pkt_end,
                   bus.stuff_err, bus.sync_err, bus.pkt_len};
            n_vec++;
            if (obs !== 13'd0) begin
                n_mis++;
                $display("FAIL reset_hold[%0d]: outputs %b, want all 0", i, obs);
            end
        end
        rst = 1'b0;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        obs = {bus.out_bit, bus.out_valid, bus.pkt_start, bus.pkt_end,
               bus.stuff_err, bus.sync_err, bus.pkt_len};
        n_vec++;
        if (obs !== 13'd0) begin
            n_mis++;
            $display("FAIL reset_release: outputs %b, want all 0", obs);
        end
    endtask

    task automatic test_basic();
        logic [3:0] lv;
        logic e, g;
        clear_obs();
        send_sync();
        lv = 4'b0100;
        for (int i = 3; i >= 0; i--) step(lv[i], 1'b1);
        exp_q.push_back(1'b1); exp_q.push_back(1'b0);
        exp_q.push_back(1'b0); exp_q.push_back(1'b1);
        step(1'b1, 1'b0);
        n_vec++; if (n_start != 1 || start_cyc != 8) begin n_mis++; $display("FAIL basic_start: count %0d at cyc %0d, want 1 at 8", n_start, start_cyc); end
        n_vec++; if (n_vld != 4 || first_vld != 9 || last_vld != 12) begin n_mis++; $display("FAIL basic_valid: %0d bits cyc %0d..%0d, want 4 bits 9..12", n_vld, first_vld, last_vld); end
        n_vec++; if (n_end != 1 || end_cyc != 13 || end_len !== 7'd4) begin n_mis++; $display("FAIL basic_end: count %0d cyc %0d len %0d, want 1 13 4", n_end, end_cyc, end_len); end
        n_vec++; if (n_stuff != 0 || n_sync != 0) begin n_mis++; $display("FAIL basic_err: stuff %0d sync %0d, want 0 0", n_stuff, n_sync); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_vec++; if (g !== e) begin n_mis++; $display("FAIL basic_bit: got %b want %b", g, e); end
        end
        step(1'b1, 1'b0);
        n_vec++; if (bus.pkt_len !== 7'd4) begin n_mis++; $display("FAIL basic_len_hold: got %0d want 4", bus.pkt_len); end
    endtask

    task automatic test_stuff();
        logic e, g;
        clear_obs();
        send_sync();
        for (int i = 0; i < 5; i++) begin step(1'b0, 1'b1); exp_q.push_back(1'b1); end
        step(1'b1, 1'b1);                       // stuff bit
        step(1'b1, 1'b1); exp_q.push_back(1'b1);
        step(1'b1, 1'b0);
        n_vec++; if (n_vld != 6 || first_vld != 9 || last_vld != 15) begin n_mis++; $display("FAIL stuff_valid: %0d bits cyc %0d..%0d, want 6 bits 9..15", n_vld, first_vld, last_vld); end
        n_vec++; if (n_end != 1 || end_len !== 7'd6) begin n_mis++; $display("FAIL stuff_end: count %0d len %0d, want 1 6", n_end, end_len); end
        n_vec++; if (n_stuff != 0) begin n_mis++; $display("FAIL stuff_noerr: got %0d want 0", n_stuff); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_vec++; if (g !== e) begin n_mis++; $display("FAIL stuff_bit: got %b want %b", g, e); end
        end
        // EOP exactly at a pending stuff position closes cleanly.
        clear_obs();
        send_sync();
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        n_vec++; if (n_end != 1 || end_len !== 7'd5 || n_stuff != 0) begin n_mis++; $display("FAIL stuff_eop: end %0d len %0d err %0d, want 1 5 0", n_end, end_len, n_stuff); end
    endtask

    task automatic test_stuff_err();
        logic e, g;
        clear_obs();
        send_sync();
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1);
        for (int i = 0; i < 5; i++) exp_q.push_back(1'b1);
        step(1'b1, 1'b1); step(1'b0, 1'b1); step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        n_vec++; if (n_stuff != 1 || err_cyc != 14) begin n_mis++; $display("FAIL serr_pulse: count %0d cyc %0d, want 1 at 14", n_stuff, err_cyc); end
        n_vec++; if (n_vld != 5 || last_vld != 13) begin n_mis++; $display("FAIL serr_valid: %0d bits last %0d, want 5 last 13", n_vld, last_vld); end
        n_vec++; if (n_end != 0) begin n_mis++; $display("FAIL serr_noend: got %0d want 0", n_end); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_vec++; if (g !== e) begin n_mis++; $display("FAIL serr_bit: got %b want %b", g, e); end
        end
        // Next packet decodes normally: levels 1,1,0,1 after SYNC -> 0,1,0,0.
        clear_obs();
        send_sync();
        step(1'b1, 1'b1); step(1'b1, 1'b1); step(1'b0, 1'b1); step(1'b1, 1'b1);
        exp_q.push_back(1'b0); exp_q.push_back(1'b1);
        exp_q.push_back(1'b0); exp_q.push_back(1'b0);
        step(1'b1, 1'b0);
        n_vec++; if (n_start != 1 || n_end != 1 || end_len !== 7'd4 || n_stuff != 0) begin n_mis++; $display("FAIL serr_next: start %0d end %0d len %0d err %0d, want 1 1 4 0", n_start, n_end, end_len, n_stuff); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_vec++; if (g !== e) begin n_mis++; $display("FAIL serr_next_bit: got %b want %b", g, e); end
        end
    endtask

    task automatic test_abort();
        logic [7:0] lv;
        logic e, g;
        // Case A: drop after 4 SYNC bits, then drop on the SYNC-completing bit.
        clear_obs();
        lv = 8'b0101_0100;
        for (int i = 7; i >= 4; i--) step(lv[i], 1'b1);
        step(1'b1, 1'b0);
        for (int i = 7; i >= 1; i--) step(lv[i], 1'b1);
        step(lv[0], 1'b0);
        step(1'b1, 1'b0);
        n_vec++; if (n_start != 0 || n_vld != 0 || n_end != 0 || n_stuff != 0 || n_sync != 0) begin n_mis++; $display("FAIL abort_hunt: start %0d vld %0d end %0d serr %0d yerr %0d, want all 0", n_start, n_vld, n_end, n_stuff, n_sync); end
        // Case B: reset mid-DATA.
        clear_obs();
        send_sync();
        step(1'b0, 1'b1); step(1'b1, 1'b1); step(1'b0, 1'b1);
        n_vec++; if (bus.pkt_len !== 7'd3) begin n_mis++; $display("FAIL abort_len_pre: got %0d want 3", bus.pkt_len); end
        rst = 1'b1;
        step(1'b1, 1'b1);
        n_vec++; if ({bus.out_valid, bus.pkt_start, bus.pkt_end, bus.stuff_err, bus.out_bit} !== 5'd0 || bus.pkt_len !== 7'd0) begin n_mis++; $display("FAIL abort_rst: vld %b end %b len %0d, want 0 0 0", bus.out_valid, bus.pkt_end, bus.pkt_len); end
        rst = 1'b0;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        n_vec++; if (n_end != 0 || n_stuff != 0) begin n_mis++; $display("FAIL abort_noend: end %0d err %0d, want 0 0", n_end, n_stuff); end
        // Case C: fresh packet afterwards.
        clear_obs();
        send_sync();
        for (int i = 0; i < 16; i++) send_bit(logic'($urandom_range(3, 0) != 0));
        step(1'b1, 1'b0);
        n_vec++; if (n_start != 1 || n_end != 1 || end_len !== 7'd16) begin n_mis++; $display("FAIL abort_fresh: start %0d end %0d len %0d, want 1 1 16", n_start, n_end, end_len); end
        n_vec++; if (got_q.size() != exp_q.size()) begin n_mis++; $display("FAIL abort_fresh_cnt: got %0d bits want %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_vec++; if (g !== e) begin n_mis++; $display("FAIL abort_fresh_bit: got %b want %b", g, e); end
        end
    endtask

    task automatic test_saturate();
        logic e, g;
        int bad;
        clear_obs();
        send_sync();
        for (int i = 0; i < 135; i++) send_bit(logic'($urandom_range(3, 0) != 0));
        step(1'b1, 1'b0);
        n_vec++; if (n_end != 1 || end_len !== 7'd127) begin n_mis++; $display("FAIL sat_len: end %0d len %0d, want 1 127", n_end, end_len); end
        n_vec++; if (n_vld != 135 || n_stuff != 0) begin n_mis++; $display("FAIL sat_bits: %0d bits err %0d, want 135 0", n_vld, n_stuff); end
        bad = 0;
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            if (g !== e) bad++;
        end
        n_vec++; if (bad != 0) begin n_mis++; $display("FAIL sat_data: %0d wrong bits, want 0", bad); end
    endtask

    task automatic test_back_to_back();
        logic e, g;
        clear_obs();
        send_sync();
        for (int i = 0; i < 12; i++) send_bit(logic'($urandom_range(3, 0) != 0));
        step(1'b1, 1'b0);
        n_vec++; if (bus.pkt_end !== 1'b1 || bus.pkt_len !== 7'd12) begin n_mis++; $display("FAIL b2b_first: end %b len %0d, want 1 12", bus.pkt_end, bus.pkt_len); end
        send_sync();
        for (int i = 0; i < 9; i++) send_bit(logic'($urandom_range(3, 0) != 0));
        step(1'b1, 1'b0);
        n_vec++; if (n_start != 2 || n_end != 2 || end_len !== 7'd9) begin n_mis++; $display("FAIL b2b_second: start %0d end %0d len %0d, want 2 2 9", n_start, n_end, end_len); end
        n_vec++; if (got_q.size() != 21) begin n_mis++; $display("FAIL b2b_cnt: got %0d bits want 21", got_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_vec++; if (g !== e) begin n_mis++; $display("FAIL b2b_bit: got %b want %b", g, e); end
        end
    endtask

    task automatic test_sync_window();
        logic [8:0] lv;
        logic e, g;
        clear_obs();
        lv = 9'b1_0101_0100;
        for (int i = 8; i >= 0; i--) step(lv[i], 1'b1);
        step(1'b1, 1'b1); step(1'b0, 1'b1);
        exp_q.push_back(1'b0); exp_q.push_back(1'b0);
        step(1'b1, 1'b0);
`ifdef RX_SYNC_STRICT_EN
        n_vec++; if (n_sync != 1 || err_cyc != 8) begin n_mis++; $display("FAIL strict_err: count %0d cyc %0d, want 1 at 8", n_sync, err_cyc); end
        n_vec++; if (n_start != 0 || n_vld != 0 || n_end != 0) begin n_mis++; $display("FAIL strict_quiet: start %0d vld %0d end %0d, want 0 0 0", n_start, n_vld, n_end); end
`else
        n_vec++; if (n_start != 1 || start_cyc != 9 || n_sync != 0) begin n_mis++; $display("FAIL slide_start: count %0d cyc %0d syncerr %0d, want 1 9 0", n_start, start_cyc, n_sync); end
        n_vec++; if (n_end != 1 || end_len !== 7'd2) begin n_mis++; $display("FAIL slide_end: count %0d len %0d, want 1 2", n_end, end_len); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_vec++; if (g !== e) begin n_mis++; $display("FAIL slide_bit: got %b want %b", g, e); end
        end
`endif
    endtask

    initial begin
        rst          = 1'b1;
        bus.in_bit   = 1'b1;
        bus.in_valid = 1'b0;
        tx_level     = 1'b1;
        tx_ones      = 0;
        clear_obs();
        test_reset();
        test_basic();
        test_stuff();
        test_stuff_err();
        test_abort();
        test_saturate();
        test_back_to_back();
        test_sync_window();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
